rect_plotter: RTL and testbench
===============================

# rect_plotter

Pixel-plotting engine that acts as the receiving end of the draw-command interface used by the game's drawing controllers (paddle, ball, score). A client hands over one rectangle command (origin, width, height, colour) with a valid/ready handshake. The block streams one pixel per clock to the `vga_adapter` as x/y/colour/plot and pulses `done` when the rectangle is finished. This lets erase and redraw logic in each object controller issue a single command instead of running its own pixel counter.

## Interface
Parameters:
- `X_W`, 8, x coordinate width
- `Y_W`, 7, y coordinate width
- `C_W`, 3, colour width
- `SZ_W`, 5, width/height field width (sizes 0..31)
- `SCR_W`, 160, visible columns
- `SCR_H`, 120, visible rows

Ports:
- `clk`  in  1  system clock (CLOCK_50)
- `resetn`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  client presents a command
- `cmd_ready`  out  1  engine can accept a command
- `cmd_x`  in  X_W  rectangle left column
- `cmd_y`  in  Y_W  rectangle top row
- `cmd_w`  in  SZ_W  width in pixels
- `cmd_h`  in  SZ_W  height in pixels
- `cmd_colour`  in  C_W  fill colour
- `x`  out  X_W  pixel column to the VGA adapter
- `y`  out  Y_W  pixel row to the VGA adapter
- `colour`  out  C_W  pixel colour
- `plot`  out  1  write strobe to the VGA adapter
- `busy`  out  1  a command is in progress (state is not IDLE)
- `done`  out  1  one-cycle pulse when a command completes

## Operation
- States: IDLE, PLOT, DONE.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid & cmd_ready`, capture x0, y0, w, h and colour, and clear counters cx and cy.
  - If w==0 or h==0, go to DONE. Otherwise go to PLOT.
- **PLOT**
  - Presents pixel (x0+cx, y0+cy) with the latched colour.
  - cx increments each cycle. When cx==w-1, cx wraps to 0 and cy increments.
  - When cx==w-1 and cy==h-1, go to DONE.
  - Scan order is row-major, left to right, then top to bottom.
- **DONE**
  - `done`=1 and `cmd_ready`=0 for exactly one cycle, then go to IDLE.
- Arithmetic and clipping:
  - x0+cx is computed in X_W+1 bits and y0+cy in Y_W+1 bits.
  - `plot`=1 only in PLOT and only when the sum is below SCR_W (x) and below SCR_H (y).
  - Off-screen pixels still take one cycle each. `plot`=0 for them.
  - `x` and `y` outputs are the truncated low bits of the sums.
- `cmd_*` inputs are ignored outside IDLE. Command fields are latched and do not need to stay stable after acceptance.
- `colour` outputs the latched colour in all states.
- Reset values (asynchronous):
  - state IDLE; cx, cy, x0, y0, w, h and colour 0.
  - Outputs: `x`=0, `y`=0, `colour`=0, `plot`=0, `busy`=0, `done`=0, `cmd_ready`=1.
- Reset mid-command: `plot` and `busy` drop immediately, with no completion `done`. After release, the engine accepts a new command on the first edge with `cmd_valid`.

## Timing
- Command accepted on edge k; the first pixel is presented in cycle k+1.
- A w×h command occupies PLOT for w·h cycles, pixels on cycles k+1 .. k+w·h.
- `done` is high in cycle k+w·h+1. `cmd_ready` returns in cycle k+w·h+2.
- Zero-size command: `done` in cycle k+1, with no `plot`.
- Back-to-back commands: minimum spacing is w·h+2 cycles between acceptances.
- Outputs are decoded combinationally from registered state, counters and latches. There are no combinational paths from `cmd_*` to any output except none (`cmd_ready` depends only on state).
- The `vga_adapter` samples `plot`, `x`, `y` and `colour` on the same `clk` edge.

## Structure
- Shared package `pong_pkg`:
  - SCR_W, SCR_H, X_W, Y_W, C_W.
  - Colour constants: BLACK=3'b000, WHITE=3'b111, BG=3'b011.
  - State encoding localparams for rect_plotter.
- One sub-module, `rect_scan_counter`:
  - Holds cx/cy, with clear, enable, w/h inputs and a `last` output (cx==w-1 and cy==h-1).
  - The top level holds the FSM, latches and clip logic.

## Test plan
- Reset, then a command x=75, y=110, w=16, h=1, colour=111 → 16 cycles of `plot` with x=75..90 and y=110, then `done` for 1 cycle, then `cmd_ready`=1.
- w=3, h=2 at (10,20) → pixels (10,20), (11,20), (12,20), (10,21), (11,21), (12,21) in order, `done` at acceptance+7.
- Clipping: x=158, y=119, w=4, h=2 → `plot`=1 only for (158,119) and (159,119); 8 PLOT cycles total; `done` still fires.
- w=0, h=5 → no `plot`; `done` at acceptance+1.
- `cmd_valid` held high continuously with a changing `cmd_x` → second command accepted only in the cycle after `done`. The first rectangle uses its originally latched x.
- `resetn` pulsed low mid-rectangle → `plot`, `busy` and `done` are 0 immediately; `cmd_ready`=1. The next command runs normally from its origin.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared constants for the pong drawing path: screen geometry, field widths,
// colour constants and the rect_plotter state encoding.
package pong_pkg;

  // Visible screen and coordinate field widths
  localparam int SCR_W = 160;
  localparam int SCR_H = 120;
  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int C_W   = 3;
  localparam int SZ_W  = 5;

  // Colours used by the object controllers
  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] WHITE = 3'b111;
  localparam logic [2:0] BG    = 3'b011;

  // rect_plotter state encoding
  localparam int         ST_W    = 2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLOT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Debug view of the plotter: FSM state plus scan position
  typedef struct packed {
    logic [ST_W-1:0] state;
    logic [SZ_W-1:0] cx;
    logic [SZ_W-1:0] cy;
  } rp_dbg_t;

endpackage

// File: rtl/rect_plotter_if.sv
// Draw-command and pixel-stream bundle between a drawing client and the
// rectangle plotter.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both 1. cmd_ready depends only on the plotter state, never on
// cmd_valid. The client may change or drop the cmd_* fields at any time;
// they are only sampled on the transfer edge.
interface rect_plotter_if #(
  parameter int X_W  = pong_pkg::X_W,
  parameter int Y_W  = pong_pkg::Y_W,
  parameter int C_W  = pong_pkg::C_W,
  parameter int SZ_W = pong_pkg::SZ_W
) ();

  // Command side
  logic            cmd_valid;
  logic            cmd_ready;
  logic [X_W-1:0]  cmd_x;
  logic [Y_W-1:0]  cmd_y;
  logic [SZ_W-1:0] cmd_w;
  logic [SZ_W-1:0] cmd_h;
  logic [C_W-1:0]  cmd_colour;

  // Pixel side towards vga_adapter, plus status
  logic [X_W-1:0]  x;
  logic [Y_W-1:0]  y;
  logic [C_W-1:0]  colour;
  logic            plot;
  logic            busy;
  logic            done;

  // Drawing controller side
  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour,
    input  cmd_ready, x, y, colour, plot, busy, done
  );

  // Plotter side
  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour,
    output cmd_ready, x, y, colour, plot, busy, done
  );

endinterface

// File: rtl/rect_scan_counter.sv
// Row-major scan counter for a w x h rectangle: cx runs 0..w-1, then wraps
// and advances cy. 'last' marks the final pixel of the rectangle.
module rect_scan_counter #(
  parameter int SZ_W = pong_pkg::SZ_W
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic [SZ_W-1:0] w_i,
  input  logic [SZ_W-1:0] h_i,
  output logic [SZ_W-1:0] cx_o,
  output logic [SZ_W-1:0] cy_o,
  output logic            last_o
);
  import pong_pkg::*;

  logic [SZ_W-1:0] cx_q, cx_d;
  logic [SZ_W-1:0] cy_q, cy_d;
  logic            row_end;

  assign row_end = (cx_q == w_i - 1'b1);
  assign last_o  = row_end && (cy_q == h_i - 1'b1);
  assign cx_o    = cx_q;
  assign cy_o    = cy_q;

  // Next position: clear wins, otherwise step along the row and wrap to the next
  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (clr_i) begin
      cx_d = '0;
      cy_d = '0;
    end else if (en_i) begin
      if (row_end) begin
        cx_d = '0;
        cy_d = cy_q + 1'b1;
      end else begin
        cx_d = cx_q + 1'b1;
      end
    end
  end

  // Position registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

endmodule

// File: rtl/rect_plotter.sv
// Rectangle fill engine: accepts one draw command, streams one pixel per clock
// to the VGA adapter (clipping off-screen pixels by holding plot low), then
// pulses done for one cycle.
module rect_plotter #(
  parameter int X_W   = pong_pkg::X_W,
  parameter int Y_W   = pong_pkg::Y_W,
  parameter int C_W   = pong_pkg::C_W,
  parameter int SZ_W  = pong_pkg::SZ_W,
  parameter int SCR_W = pong_pkg::SCR_W,
  parameter int SCR_H = pong_pkg::SCR_H
) (
  input  logic        clk,
  input  logic        resetn,
  rect_plotter_if.slave bus,
  output logic [1:0]  dbg_state_o
);
  import pong_pkg::*;

  logic [1:0]      state_q, state_d;
  logic [X_W-1:0]  x0_q, x0_d;
  logic [Y_W-1:0]  y0_q, y0_d;
  logic [SZ_W-1:0] w_q, w_d;
  logic [SZ_W-1:0] h_q, h_d;
  logic [C_W-1:0]  col_q, col_d;

  logic            accept;
  logic            in_plot;
  logic [SZ_W-1:0] cx;
  logic [SZ_W-1:0] cy;
  logic            last;
  logic [X_W:0]    sx;
  logic [Y_W:0]    sy;

  assign accept  = bus.cmd_valid && (state_q == ST_IDLE);
  assign in_plot = (state_q == ST_PLOT);

  rect_scan_counter #(.SZ_W(SZ_W)) u_scan (
    .clk    (clk),
    .resetn (resetn),
    .clr_i  (accept),
    .en_i   (in_plot),
    .w_i    (w_q),
    .h_i    (h_q),
    .cx_o   (cx),
    .cy_o   (cy),
    .last_o (last)
  );

  // FSM transitions and command capture
  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    w_d     = w_q;
    h_d     = h_q;
    col_d   = col_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          x0_d  = bus.cmd_x;
          y0_d  = bus.cmd_y;
          w_d   = bus.cmd_w;
          h_d   = bus.cmd_h;
          col_d = bus.cmd_colour;
          if ((bus.cmd_w == '0) || (bus.cmd_h == '0)) state_d = ST_DONE;
          else                                        state_d = ST_PLOT;
        end
      end
      ST_PLOT: begin
        if (last) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and command latches
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      w_q     <= w_d;
      h_q     <= h_d;
      col_q   <= col_d;
    end
  end

  // Pixel address is one bit wider than the screen field so that
  // rectangles hanging off the right/bottom edge are detected, not wrapped.
  assign sx = {1'b0, x0_q} + {{(X_W + 1 - SZ_W){1'b0}}, cx};
  assign sy = {1'b0, y0_q} + {{(Y_W + 1 - SZ_W){1'b0}}, cy};

  assign bus.x         = sx[X_W-1:0];
  assign bus.y         = sy[Y_W-1:0];
  assign bus.colour    = col_q;
  assign bus.plot      = in_plot && (sx < (X_W + 1)'(SCR_W)) && (sy < (Y_W + 1)'(SCR_H));
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_rect_plotter.sv
// Directed bench for rect_plotter: each command pushes its expected pixel and
// done events (with cycle stamps) into a queue; a negedge monitor pops and
// compares whenever plot or done is seen.
`timescale 1ns/1ps
module tb_rect_plotter;

  localparam int EW = 32 + 1 + 8 + 7 + 3;

  logic clk;
  logic resetn;
  logic [1:0] dbg_state;
  int cyc;
  int checks;
  int errors;
  logic [EW-1:0] exp_q[$];

  rect_plotter_if bus ();

  rect_plotter dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every plot or done cycle must match the head of the queue
  always @(negedge clk) begin
    logic [EW-1:0] got;
    logic [EW-1:0] exp;
    if (resetn === 1'b1 && (bus.plot === 1'b1 || bus.done === 1'b1)) begin
      got = {cyc[31:0], bus.done, bus.x, bus.y, bus.colour};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output cyc=%0d done=%0d x=%0d y=%0d c=%0d",
                 cyc, bus.done, bus.x, bus.y, bus.colour);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL pixel got cyc=%0d done=%0d x=%0d y=%0d c=%0d exp cyc=%0d done=%0d x=%0d y=%0d c=%0d",
                   got[EW-1:19], got[18], got[17:10], got[9:3], got[2:0],
                   exp[EW-1:19], exp[18], exp[17:10], exp[9:3], exp[2:0]);
        end
      end
    end
  end

  // Driver: present a command, wait for acceptance, queue expected events
  task automatic send(input int x, input int y, input int w, input int h, input int c,
                      input bit keep, output int k);
    int n;
    logic [31:0] stamp;
    logic [7:0] ex;
    logic [6:0] ey;
    logic [2:0] ec;
    n = 0;
    @(negedge clk);
    bus.cmd_valid  = 1'b1;
    bus.cmd_x      = 8'(x);
    bus.cmd_y      = 7'(y);
    bus.cmd_w      = 5'(w);
    bus.cmd_h      = 5'(h);
    bus.cmd_colour = 3'(c);
    while (bus.cmd_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.cmd_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got=not_ready exp=ready (cyc %0d)", cyc);
      k = -1;
      bus.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    k = cyc;
    ec = 3'(c);
    for (int r = 0; r < h; r++) begin
      for (int q = 0; q < w; q++) begin
        if ((x + q) < 160 && (y + r) < 120) begin
          stamp = 32'(k + r * w + q);
          ex = 8'(x + q);
          ey = 7'(y + r);
          exp_q.push_back({stamp, 1'b0, ex, ey, ec});
        end
      end
    end
    stamp = 32'(k + w * h);
    ex = 8'(x + ((w == 0) ? 0 : w - 1));
    ey = 7'(y + ((h == 0) ? 0 : h - 1));
    if (w == 0 || h == 0) begin
      ex = 8'(x);
      ey = 7'(y);
    end else begin
      // counters wrap to (0, h) after the last pixel: x back at origin, y one past bottom
      ex = 8'(x);
      ey = 7'(y + h);
    end
    exp_q.push_back({stamp, 1'b1, ex, ey, ec});
    if (!keep) bus.cmd_valid = 1'b0;
  endtask

  // Completion timing: done in the last cycle, ready back one cycle later
  task automatic finish_check(input string name, input int k, input int n);
    int guard;
    guard = 0;
    while (cyc < k + n && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk({name, "_done"}, 32'(bus.done), 32'd1);
    chk({name, "_ready_during_done"}, 32'(bus.cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    chk({name, "_ready_after"}, 32'(bus.cmd_ready), 32'd1);
    chk({name, "_busy_after"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int k1, k2;
    int guard;
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_x      = '0;
    bus.cmd_y      = '0;
    bus.cmd_w      = '0;
    bus.cmd_h      = '0;
    bus.cmd_colour = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", 32'(bus.x), 32'd0);
    chk("rst_y", 32'(bus.y), 32'd0);
    chk("rst_colour", 32'(bus.colour), 32'd0);
    chk("rst_plot", 32'(bus.plot), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Horizontal bar
    send(75, 110, 16, 1, 7, 1'b0, k1);
    finish_check("bar", k1, 16);

    // 3x2 block
    send(10, 20, 3, 2, 6, 1'b0, k1);
    finish_check("blk", k1, 6);

    // Clipped at the bottom-right corner
    send(158, 119, 4, 2, 7, 1'b0, k1);
    finish_check("clip", k1, 8);

    // Zero width
    send(5, 5, 0, 5, 1, 1'b0, k1);
    finish_check("zero", k1, 0);

    // Back-to-back with cmd_valid held high and cmd_x changing meanwhile
    send(40, 5, 2, 2, 3, 1'b1, k1);
    send(100, 6, 1, 1, 5, 1'b0, k2);
    chk("b2b_spacing", 32'(k2 - k1), 32'd6);
    finish_check("b2b", k2, 1);

    // Reset in the middle of a rectangle
    send(50, 50, 4, 4, 2, 1'b0, k1);
    @(posedge clk);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_plot", 32'(bus.plot), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_ready", 32'(bus.cmd_ready), 32'd1);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    send(0, 0, 2, 1, 1, 1'b0, k1);
    finish_check("post_rst", k1, 2);

    // Drain
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(posedge clk);
      guard++;
    end
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
